// File: rtl/baud_detector_pkg.sv
// Shared auto-baud definitions: baud codes, detector FSM states, default width thresholds.
// The CONFIRM states exist only when BAUD_DETECT_CONFIRM_EN is defined.
package baud_pkg;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  // Widths in 50 MHz sys_clk cycles
  localparam int unsigned MIN_W = 217;
  localparam int unsigned MAX_W = 7812;
  localparam int unsigned TH_0  = 3906;
  localparam int unsigned TH_1  = 1736;
  localparam int unsigned TH_2  = 651;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_FALL,
    ST_MEASURE
`ifdef BAUD_DETECT_CONFIRM_EN
    ,
    ST_CONFIRM_FALL,
    ST_CONFIRM_MEASURE
`endif
  } state_e;

  function automatic logic [1:0] baud_code(int unsigned w, int unsigned th0,
                                           int unsigned th1, int unsigned th2);
    if (w >= th0)      return BAUD_9600;
    else if (w >= th1) return BAUD_19200;
    else if (w >= th2) return BAUD_57600;
    else               return BAUD_115200;
  endfunction

endpackage

// File: rtl/baud_detector_if.sv
// Control/result bundle between the auto-baud detector and its user.
interface baud_detector_if;
  logic       enable;
  logic       start;
  logic       rx;
  logic [1:0] usr_option;
  logic       valid;
  logic       error;
  logic       busy;

  modport master (output enable, start, rx, input usr_option, valid, error, busy);
  modport slave  (input enable, start, rx, output usr_option, valid, error, busy);
endinterface

// File: rtl/baud_detector_sync_edge.sv
// 2-flop synchronizer with one-cycle rise/fall pulses; flops reset to the idle-high line level.
module sync_edge (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic meta, sync, dly;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      dly  <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign dout = sync;
  assign rise = sync & ~dly;
  assign fall = ~sync & dly;
endmodule

// File: rtl/baud_detector.sv
// Auto-baud detector: times the first low bit of a sync character and maps it to a baud code.
// Define BAUD_DETECT_CONFIRM_EN to require a second matching low pulse before reporting valid.
module baud_detector #(
  parameter int unsigned CNT_W = 13,
  parameter int unsigned MIN_W = baud_pkg::MIN_W,
  parameter int unsigned MAX_W = baud_pkg::MAX_W,
  parameter int unsigned TH_0  = baud_pkg::TH_0,
  parameter int unsigned TH_1  = baud_pkg::TH_1,
  parameter int unsigned TH_2  = baud_pkg::TH_2
) (
  input logic            sys_clk,
  input logic            reset_n,
  baud_detector_if.slave bus
);
  import baud_pkg::*;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             rx_s, rx_rise, rx_fall;
  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       opt, opt_nx;
  logic             vld, vld_nx, err, err_nx;
  logic             in_rng, at_max;
  logic [1:0]       code;
`ifdef BAUD_DETECT_CONFIRM_EN
  logic [1:0]       code1, code1_nx;
`endif

  sync_edge u_sync (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .din     (bus.rx),
    .dout    (rx_s),
    .rise    (rx_rise),
    .fall    (rx_fall)
  );

  assign in_rng = (32'(cnt) >= MIN_W) && (32'(cnt) <= MAX_W);
  assign at_max = 32'(cnt) >= MAX_W;
  assign code   = baud_code(32'(cnt), TH_0, TH_1, TH_2);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      opt   <= BAUD_9600;
      vld   <= 1'b0;
      err   <= 1'b0;
`ifdef BAUD_DETECT_CONFIRM_EN
      code1 <= BAUD_9600;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      opt   <= opt_nx;
      vld   <= vld_nx;
      err   <= err_nx;
`ifdef BAUD_DETECT_CONFIRM_EN
      code1 <= code1_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    opt_nx   = opt;
    vld_nx   = vld;
    err_nx   = err;
`ifdef BAUD_DETECT_CONFIRM_EN
    code1_nx = code1;
`endif
    if (!bus.enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          if (bus.start) begin
            state_nx = ST_ARM;
            vld_nx   = 1'b0;
            err_nx   = 1'b0;
            cnt_nx   = '0;
          end
        // Wait for idle-high so a line already low is never timed mid-bit
        ST_ARM:
          if (rx_s) state_nx = ST_WAIT_FALL;
        ST_WAIT_FALL:
          if (rx_fall) begin
            state_nx = ST_MEASURE;
            cnt_nx   = CNT_W'(1);
          end
        ST_MEASURE:
          if (rx_rise) begin
            state_nx = ST_IDLE;
            if (!in_rng) begin
              err_nx = 1'b1;
            end else begin
`ifdef BAUD_DETECT_CONFIRM_EN
              code1_nx = code;
              state_nx = ST_CONFIRM_FALL;
`else
              opt_nx = code;
              vld_nx = 1'b1;
`endif
            end
          end else if (!rx_s) begin
            // Next low cycle would exceed MAX_W: abort without waiting for the rise
            if (at_max) begin
              state_nx = ST_IDLE;
              err_nx   = 1'b1;
            end else if (cnt != CNT_SAT) begin
              cnt_nx = cnt + 1'b1;
            end
          end
`ifdef BAUD_DETECT_CONFIRM_EN
        ST_CONFIRM_FALL:
          if (rx_fall) begin
            state_nx = ST_CONFIRM_MEASURE;
            cnt_nx   = CNT_W'(1);
          end
        ST_CONFIRM_MEASURE:
          if (rx_rise) begin
            state_nx = ST_IDLE;
            if (in_rng && code == code1) begin
              opt_nx = code;
              vld_nx = 1'b1;
            end else begin
              err_nx = 1'b1;
            end
          end else if (!rx_s) begin
            if (at_max) begin
              state_nx = ST_IDLE;
              err_nx   = 1'b1;
            end else if (cnt != CNT_SAT) begin
              cnt_nx = cnt + 1'b1;
            end
          end
`endif
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign bus.usr_option = opt;
  assign bus.valid      = vld;
  assign bus.error      = err;
  assign bus.busy       = (state != ST_IDLE);

endmodule
